ula_io_port: RTL and testbench

// Parametrised ULA port 0xFE block: decodes CPU I/O cycles, latches border/MIC/beeper, returns keyboard+EAR on reads.

---
 rtl/ula_io_port_pkg.sv | 33 +++
 rtl/ula_io_port_sigma_delta_dac.sv | 68 ++++++
 rtl/ula_io_port.sv | 218 +++++++++++++++++++++
 tb/tb_ula_io_port.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_io_port_pkg.sv
// Shared definitions for the ULA port 0xFE block: port decode, mix modes,
// default mix weights and small arithmetic helpers used by the mixer.
package ula_io_port_pkg;

    // ULA answers every even port: only A0 is decoded, and it must be low.
    localparam logic [15:0] ULA_PORT_MASK  = 16'h0001;
    localparam logic [15:0] ULA_PORT_MATCH = 16'h0000;

    // Audio mix routing selected by mix_mode.
    typedef enum logic [1:0] {
        MIX_MONO  = 2'd0,   // beeper + MIC + EAR on both channels
        MIX_SPLIT = 2'd1,   // beeper left, tape (MIC + EAR) right
        MIX_MUTE  = 2'd2,   // silence
        MIX_BEEP  = 2'd3    // beeper only, both channels
    } mix_mode_e;

    // Default 8-bit mix weights and activity hold time.
    localparam int DEF_BEEP_W   = 160;
    localparam int DEF_MIC_W    = 32;
    localparam int DEF_EAR_W    = 48;
    localparam int DEF_ACT_HOLD = 65535;

    // Gate an 8-bit weight by a single source bit, widened for summing.
    function automatic logic [9:0] weigh(input logic src, input logic [7:0] w);
        return src ? {2'b00, w} : 10'd0;
    endfunction

    // Clamp a mixer sum to the 8-bit level range.
    function automatic logic [7:0] sat_level(input logic [9:0] sum);
        return (sum > 10'd255) ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ula_io_port_sigma_delta_dac.sv
// Per-channel quantiser: reduces an IN_BITS level to OUT_BITS either by plain
// truncation or by first-order error feedback (the dropped fraction bits are
// carried into the next sample so the time-average tracks the level).
module sigma_delta_dac #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4,
    parameter int DITHER   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_BITS-1:0]  level,
    output logic [OUT_BITS-1:0] dac_out
);

    localparam int F = IN_BITS - OUT_BITS;

    logic [OUT_BITS-1:0] out_q;

    generate
        if (F == 0) begin : g_full
            // Output is as wide as the level: no fraction to carry.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) out_q <= '0;
                else       out_q <= level;
            end
        end else if (DITHER == 0) begin : g_trunc
            logic unused_frac;
            assign unused_frac = ^level[F-1:0];

            // Plain truncation: keep the top OUT_BITS of the level.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) out_q <= '0;
                else       out_q <= level[IN_BITS-1 -: OUT_BITS];
            end
        end else begin : g_sigma
            logic [F-1:0]   err_q;
            logic [F-1:0]   err_d;
            logic [IN_BITS:0] sum;
            logic [OUT_BITS-1:0] out_d;

            // Add the carried fraction; an overflow pins the output at full
            // scale and freezes the error so it cannot wind up.
            always_comb begin
                sum   = {1'b0, level} + {{(IN_BITS + 1 - F){1'b0}}, err_q};
                out_d = '1;
                err_d = err_q;
                if (!sum[IN_BITS]) begin
                    out_d = sum[IN_BITS-1 -: OUT_BITS];
                    err_d = sum[F-1:0];
                end
            end

            // Output sample and error accumulator registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                    err_q <= '0;
                end else begin
                    out_q <= out_d;
                    err_q <= err_d;
                end
            end
        end
    endgenerate

    assign dac_out = out_q;

endmodule

// File: rtl/ula_io_port.sv
// ULA port 0xFE: decodes CPU I/O cycles, latches border/MIC/beeper on writes,
// returns keyboard + EAR on reads, mixes the audio sources into per-channel
// levels and quantises them for the audio pins. Also drives a tape activity
// indicator from EAR edges.
module ula_io_port
    import ula_io_port_pkg::*;
#(
    parameter int AUDIO_BITS  = 4,
    parameter int BORDER_BITS = 3,
    parameter int DITHER      = 1,
    parameter int BEEP_W      = DEF_BEEP_W,
    parameter int MIC_W       = DEF_MIC_W,
    parameter int EAR_W       = DEF_EAR_W,
    parameter int ACT_HOLD    = DEF_ACT_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            addr,
    input  logic [7:0]             data_in,
    input  logic                   n_iorq,
    input  logic                   n_wr,
    input  logic                   n_rd,
    input  logic                   n_m1,
    input  logic [4:0]             key_data,
    input  logic                   ear_in,
    input  logic [1:0]             mix_mode,
    output logic                   rd_sel,
    output logic [7:0]             rd_data,
    output logic [BORDER_BITS-1:0] border_color,
    output logic [AUDIO_BITS-1:0]  audio_l,
    output logic [AUDIO_BITS-1:0]  audio_r,
    output logic                   tape_active
);

    localparam int CNT_W = (ACT_HOLD < 1) ? 1 : $clog2(ACT_HOLD + 1);
    localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACT_HOLD);
    localparam logic [7:0] BEEP_W8 = BEEP_W[7:0];
    localparam logic [7:0] MIC_W8  = MIC_W[7:0];
    localparam logic [7:0] EAR_W8  = EAR_W[7:0];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic port_hit;
    logic we;
    logic strobe;

    assign port_hit = ((addr & ULA_PORT_MASK) == ULA_PORT_MATCH);
    // M1 together with IORQ is an interrupt acknowledge, never a port access.
    assign we       = port_hit & ~n_iorq & ~n_wr & n_m1;
    assign rd_sel   = port_hit & ~n_iorq & ~n_rd & n_m1;

    // ------------------------------------------------------------------
    // Write latch
    // ------------------------------------------------------------------
    logic                   we_q;
    logic [BORDER_BITS-1:0] border_q, border_d;
    logic                   beep_q, beep_d;
    logic                   mic_q, mic_d;
    logic [BORDER_BITS-1:0] border_wr;

    assign strobe = we & ~we_q;

    // Border bits 0..2 are the classic colour; wider palettes take their
    // extra bits from data_in[7:5] upward, anything beyond that reads zero.
    genvar gi;
    generate
        for (gi = 0; gi < BORDER_BITS; gi++) begin : g_border
            if (gi < 3) begin : g_lo
                assign border_wr[gi] = data_in[gi];
            end else if (gi < 6) begin : g_hi
                assign border_wr[gi] = data_in[gi + 2];
            end else begin : g_zero
                assign border_wr[gi] = 1'b0;
            end
        end
    endgenerate

    logic unused_data;
    assign unused_data = ^{data_in[7:5]};

    // Latch border/MIC/beeper once per write cycle, on the strobe's rising edge.
    always_comb begin
        border_d = border_q;
        beep_d   = beep_q;
        mic_d    = mic_q;
        if (strobe) begin
            border_d = border_wr;
            mic_d    = data_in[3];
            beep_d   = data_in[4];
        end
    end

    // Port registers. we_q resets high so a write still held when reset is
    // released is treated as already seen and does not latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b1;
            border_q <= '0;
            beep_q   <= 1'b0;
            mic_q    <= 1'b0;
        end else begin
            we_q     <= we;
            border_q <= border_d;
            beep_q   <= beep_d;
            mic_q    <= mic_d;
        end
    end

    assign border_color = border_q;

    // ------------------------------------------------------------------
    // EAR synchroniser and tape activity
    // ------------------------------------------------------------------
    logic             ear_meta_q;
    logic             ear_sync_q;
    logic             ear_q;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;

    // Activity hold: reload on every EAR edge, otherwise count down to zero.
    always_comb begin
        act_cnt_d = act_cnt_q;
        if (ear_sync_q != ear_q) begin
            act_cnt_d = ACT_LOAD;
        end else if (act_cnt_q != '0) begin
            act_cnt_d = act_cnt_q - 1'b1;
        end
    end

    // Two-flop synchroniser, edge-detect delay and activity counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ear_meta_q <= 1'b0;
            ear_sync_q <= 1'b0;
            ear_q      <= 1'b0;
            act_cnt_q  <= '0;
        end else begin
            ear_meta_q <= ear_in;
            ear_sync_q <= ear_meta_q;
            ear_q      <= ear_sync_q;
            act_cnt_q  <= act_cnt_d;
        end
    end

    assign tape_active = (act_cnt_q != '0);
    assign rd_data     = {1'b1, ear_sync_q, 1'b1, key_data};

    // ------------------------------------------------------------------
    // Mixer
    // ------------------------------------------------------------------
    logic [7:0] level_l_q, level_l_d;
    logic [7:0] level_r_q, level_r_d;
    logic [9:0] beep_term, tape_term, mono_term;

    // Route weighted sources to each channel according to the mix mode.
    always_comb begin
        beep_term = weigh(beep_q, BEEP_W8);
        tape_term = weigh(mic_q, MIC_W8) + weigh(ear_sync_q, EAR_W8);
        mono_term = beep_term + tape_term;
        level_l_d = 8'd0;
        level_r_d = 8'd0;
        case (mix_mode_e'(mix_mode))
            MIX_MONO: begin
                level_l_d = sat_level(mono_term);
                level_r_d = sat_level(mono_term);
            end
            MIX_SPLIT: begin
                level_l_d = sat_level(beep_term);
                level_r_d = sat_level(tape_term);
            end
            MIX_BEEP: begin
                level_l_d = sat_level(beep_term);
                level_r_d = sat_level(beep_term);
            end
            default: begin
                level_l_d = 8'd0;
                level_r_d = 8'd0;
            end
        endcase
    end

    // Registered channel levels feeding the quantisers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_l_q <= 8'd0;
            level_r_q <= 8'd0;
        end else begin
            level_l_q <= level_l_d;
            level_r_q <= level_r_d;
        end
    end

    // ------------------------------------------------------------------
    // Quantisers
    // ------------------------------------------------------------------
    sigma_delta_dac #(
        .IN_BITS (8),
        .OUT_BITS(AUDIO_BITS),
        .DITHER  (DITHER)
    ) u_dac_l (
        .clk    (clk),
        .reset  (reset),
        .level  (level_l_q),
        .dac_out(audio_l)
    );

    sigma_delta_dac #(
        .IN_BITS (8),
        .OUT_BITS(AUDIO_BITS),
        .DITHER  (DITHER)
    ) u_dac_r (
        .clk    (clk),
        .reset  (reset),
        .level  (level_r_q),
        .dac_out(audio_r)
    );

endmodule

// File: tb/tb_ula_io_port.sv
// Bench for ula_io_port: three instances share one bus and differ in
// quantiser mode and mix weights so truncation, dithering and saturation can
// be observed side by side.
module tb_ula_io_port;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        n_iorq;
    logic        n_wr;
    logic        n_rd;
    logic        n_m1;
    logic [4:0]  key_data;
    logic        ear_in;
    logic [1:0]  mix_mode;

    logic       a_rd_sel, b_rd_sel, c_rd_sel;
    logic [7:0] a_rd_data, b_rd_data, c_rd_data;
    logic [2:0] a_border, b_border, c_border;
    logic [3:0] a_l, a_r, b_l, b_r, c_l, c_r;
    logic       a_tape, b_tape, c_tape;

    int n_cmp = 0;
    int n_err = 0;

    // A: truncation, default weights. B: dithered, level 200 with beep+EAR.
    // C: dithered, weights that saturate with all sources on.
    ula_io_port #(.AUDIO_BITS(4), .BORDER_BITS(3), .DITHER(0),
                  .BEEP_W(160), .MIC_W(32), .EAR_W(48), .ACT_HOLD(10)) dut_a (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .mix_mode(mix_mode),
        .rd_sel(a_rd_sel), .rd_data(a_rd_data), .border_color(a_border),
        .audio_l(a_l), .audio_r(a_r), .tape_active(a_tape));

    ula_io_port #(.AUDIO_BITS(4), .BORDER_BITS(3), .DITHER(1),
                  .BEEP_W(160), .MIC_W(0), .EAR_W(40), .ACT_HOLD(10)) dut_b (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .mix_mode(mix_mode),
        .rd_sel(b_rd_sel), .rd_data(b_rd_data), .border_color(b_border),
        .audio_l(b_l), .audio_r(b_r), .tape_active(b_tape));

    ula_io_port #(.AUDIO_BITS(4), .BORDER_BITS(3), .DITHER(1),
                  .BEEP_W(160), .MIC_W(32), .EAR_W(80), .ACT_HOLD(10)) dut_c (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
        .n_iorq(n_iorq), .n_wr(n_wr), .n_rd(n_rd), .n_m1(n_m1),
        .key_data(key_data), .ear_in(ear_in), .mix_mode(mix_mode),
        .rd_sel(c_rd_sel), .rd_data(c_rd_data), .border_color(c_border),
        .audio_l(c_l), .audio_r(c_r), .tape_active(c_tape));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        n_iorq;
        logic        n_rd;
        logic        n_m1;
        logic [4:0]  key;
        logic        exp_sel;
        logic        chk_data;
        logic [7:0]  exp_data;
    } rd_vec_t;

    rd_vec_t rd_tab[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic bus_idle();
        addr   = 16'hFFFF;
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        n_rd   = 1'b1;
        n_m1   = 1'b1;
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input logic m1);
        addr    = a;
        data_in = d;
        n_iorq  = 1'b0;
        n_wr    = 1'b0;
        n_rd    = 1'b1;
        n_m1    = m1;
    endtask

    initial begin
        int hi_cnt;
        int bad_cnt;

        // Reads with ear_sync=1: {1,1,1,key} when decoded.
        rd_tab[0] = '{16'h00FE, 1'b0, 1'b0, 1'b1, 5'h1E, 1'b1, 1'b1, 8'hFE};
        rd_tab[1] = '{16'h00FE, 1'b0, 1'b0, 1'b0, 5'h1E, 1'b0, 1'b0, 8'h00};
        rd_tab[2] = '{16'h00FF, 1'b0, 1'b0, 1'b1, 5'h1E, 1'b0, 1'b0, 8'h00};
        rd_tab[3] = '{16'h00FE, 1'b1, 1'b0, 1'b1, 5'h1E, 1'b0, 1'b0, 8'h00};
        rd_tab[4] = '{16'h00FE, 1'b0, 1'b1, 1'b1, 5'h1E, 1'b0, 1'b0, 8'h00};
        rd_tab[5] = '{16'h7FFE, 1'b0, 1'b0, 1'b1, 5'h15, 1'b1, 1'b1, 8'hF5};
        rd_tab[6] = '{16'hBFFE, 1'b0, 1'b0, 1'b1, 5'h00, 1'b1, 1'b1, 8'hE0};

        reset    = 1'b1;
        bus_idle();
        data_in  = 8'h00;
        key_data = 5'h1F;
        ear_in   = 1'b0;
        mix_mode = 2'd0;

        // Reset state.
        repeat (2) tick();
        check("rst_border", a_border, 3'd0);
        check("rst_audio_l", a_l, 4'd0);
        check("rst_audio_r", a_r, 4'd0);
        check("rst_tape", a_tape, 1'b0);
        check("rst_c_audio", c_l, 4'd0);
        reset = 1'b0;
        repeat (2) tick();

        // OUT (0xFE),0x15 held 4 clocks; data changes mid-hold must not latch.
        io_write(16'h00FE, 8'h15, 1'b1);
        #1;
        check("wr_pre_border", a_border, 3'd0);
        tick();
        check("wr_border", a_border, 3'd5);
        check("wr_lat0_audio", a_l, 4'd0);
        data_in = 8'h02;
        tick();
        check("wr_lat1_audio", a_l, 4'd0);
        tick();
        check("wr_lat2_audio_l", a_l, 4'hA);
        check("wr_lat2_audio_r", a_r, 4'hA);
        tick();
        check("wr_single_latch", a_border, 3'd5);
        bus_idle();
        tick();

        // Write during interrupt acknowledge (M1 low) is ignored.
        io_write(16'h00FE, 8'h07, 1'b0);
        repeat (2) tick();
        check("m1_no_latch", a_border, 3'd5);
        check("m1_audio", a_l, 4'hA);
        bus_idle();
        tick();

        // EAR toggle: tape_active rises 3 clocks later and lasts 10 clocks.
        ear_in = 1'b1;
        tick();
        check("ear_t1", a_tape, 1'b0);
        tick();
        check("ear_t2", a_tape, 1'b0);
        tick();
        check("ear_t3", a_tape, 1'b1);
        repeat (9) tick();
        check("ear_hold_last", a_tape, 1'b1);
        tick();
        check("ear_hold_end", a_tape, 1'b0);
        check("mono_ear_audio", a_l, 4'hD);

        // Level 200 with 4 output bits: alternating 12/13, half the time 13.
        hi_cnt  = 0;
        bad_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (b_l == 4'd13) hi_cnt++;
            else if (b_l != 4'd12) bad_cnt++;
            if (b_r != b_l) bad_cnt++;
        end
        check("dither_hi_count", hi_cnt, 8);
        check("dither_bad_count", bad_cnt, 0);

        // Port read decode table.
        for (int i = 0; i < 7; i++) begin
            addr     = rd_tab[i].addr;
            n_iorq   = rd_tab[i].n_iorq;
            n_rd     = rd_tab[i].n_rd;
            n_wr     = 1'b1;
            n_m1     = rd_tab[i].n_m1;
            key_data = rd_tab[i].key;
            #1;
            check($sformatf("rd_sel[%0d]", i), a_rd_sel, rd_tab[i].exp_sel);
            if (rd_tab[i].chk_data)
                check($sformatf("rd_data[%0d]", i), a_rd_data, rd_tab[i].exp_data);
        end
        bus_idle();
        key_data = 5'h1F;
        tick();

        // Retoggle partway through the hold reloads the counter.
        ear_in = 1'b0;
        repeat (3) tick();
        check("retog_rise", a_tape, 1'b1);
        repeat (5) tick();
        ear_in = 1'b1;
        repeat (3) tick();
        repeat (9) tick();
        check("retog_reload_hold", a_tape, 1'b1);
        tick();
        check("retog_reload_end", a_tape, 1'b0);

        // All sources on: C saturates at 255.
        io_write(16'h00FE, 8'h1E, 1'b1);
        tick();
        bus_idle();
        check("sat_border", a_border, 3'd6);
        repeat (3) tick();
        bad_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (c_l != 4'hF) bad_cnt++;
            if (c_r != 4'hF) bad_cnt++;
        end
        check("sat_hold_f", bad_cnt, 0);
        check("mono_all_a", a_l, 4'hF);

        // Mode 1: beeper left, tape right.
        mix_mode = 2'd1;
        repeat (2) tick();
        check("split_l", a_l, 4'hA);
        check("split_r", a_r, 4'h5);

        // Mode 3: beeper only on both.
        mix_mode = 2'd3;
        repeat (2) tick();
        check("beep_l", a_l, 4'hA);
        check("beep_r", a_r, 4'hA);

        // Back to mono, then mute: zero exactly two clocks after the change.
        mix_mode = 2'd0;
        repeat (3) tick();
        check("premute_c", c_l, 4'hF);
        mix_mode = 2'd2;
        tick();
        check("mute_lat1", c_l, 4'hF);
        tick();
        check("mute_c_l", c_l, 4'd0);
        check("mute_c_r", c_r, 4'd0);
        check("mute_a_l", a_l, 4'd0);
        mix_mode = 2'd0;
        repeat (3) tick();
        check("unmute_a", a_l, 4'hF);

        // Reset during a write strobe with tape activity running.
        ear_in = 1'b0;
        repeat (4) tick();
        check("prerst_tape", a_tape, 1'b1);
        io_write(16'h00FE, 8'h13, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_border", a_border, 3'd0);
        check("async_audio_l", a_l, 4'd0);
        check("async_audio_r", a_r, 4'd0);
        check("async_tape", a_tape, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check("held_no_latch", a_border, 3'd0);
        check("held_audio", a_l, 4'd0);
        bus_idle();
        repeat (2) tick();

        // Normal writes work again after reset.
        io_write(16'h00FE, 8'h03, 1'b1);
        tick();
        bus_idle();
        check("post_rst_write", a_border, 3'd3);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
